// File: rtl/sha256_stream.sv
// Streaming SHA-256 / SHA-224 compression engine for pre-padded 512-bit blocks.
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   blk_valid_i/ready_o  block handshake; blk_i holds W0 in [511:480]
//   first_i, last_i      message framing, qualified by the block handshake
//   mode224_i            SHA-224 select, sampled on a message-starting block
//   md_o/md_valid_o      digest, held until md_ready_i
//   busy_o               engine not idle
module sha256_stream #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned SUPPORT_224      = 1
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_i,
  input  logic         first_i,
  input  logic         last_i,
  input  logic         mode224_i,
  output logic [255:0] md_o,
  output logic         md_valid_o,
  input  logic         md_ready_i,
  output logic         busy_o
);

  localparam int unsigned CYCLES   = 64 / ROUNDS_PER_CYCLE;
  localparam logic [5:0]  LAST_CYC = 6'(CYCLES - 1);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  rnd_q;
  logic        last_q;
  logic        chain_q;
  logic        mode_q;
  logic [31:0] h_q    [8];
  logic [31:0] work_q [8];
  logic [31:0] work_d [8];
  logic [31:0] w_q    [16];
  logic [31:0] w_d    [16];
  logic [31:0] iv_sel [8];
  logic [255:0] digest_c;
  logic [31:0] t1, t2, nw;
  logic [5:0]  kidx;
  logic        accept;
  logic        restart;
  logic        mode_sel;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign accept   = blk_valid_i & blk_ready_o;
  // A non-first block with no live chain starts a fresh message anyway.
  assign restart  = first_i | ~chain_q;
  assign mode_sel = (SUPPORT_224 != 0) ? mode224_i : 1'b0;

  always_comb begin
    for (int i = 0; i < 8; i++) iv_sel[i] = mode_sel ? IV224[i] : IV256[i];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (rnd_q == LAST_CYC) state_d = UPDATE;
      UPDATE:  state_d = last_q ? DONE : IDLE;
      DONE:    if (md_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      blk_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      md_valid_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_ready_o <= (state_d == IDLE);
      busy_o      <= (state_d != IDLE);
      md_valid_o  <= (state_d == DONE);
    end
  end

  // ROUNDS_PER_CYCLE compression rounds with a sliding 16-word schedule window.
  always_comb begin
    w_d    = w_q;
    work_d = work_q;
    t1     = '0;
    t2     = '0;
    nw     = '0;
    kidx   = '0;
    for (int r = 0; r < int'(ROUNDS_PER_CYCLE); r++) begin
      kidx = rnd_q * 6'(ROUNDS_PER_CYCLE) + 6'(r);
      t1 = work_d[7] + big_s1(work_d[4]) +
           ((work_d[4] & work_d[5]) ^ (~work_d[4] & work_d[6])) + K[kidx] + w_d[0];
      t2 = big_s0(work_d[0]) +
           ((work_d[0] & work_d[1]) ^ (work_d[0] & work_d[2]) ^ (work_d[1] & work_d[2]));
      nw = small_s1(w_d[14]) + w_d[9] + small_s0(w_d[1]) + w_d[0];
      for (int j = 7; j > 0; j--) work_d[j] = work_d[j-1];
      work_d[4] = work_d[4] + t1;
      work_d[0] = t1 + t2;
      for (int j = 0; j < 15; j++) w_d[j] = w_d[j+1];
      w_d[15] = nw;
    end
  end

  // Final chaining values as they will appear after UPDATE.
  always_comb begin
    digest_c = '0;
    for (int i = 0; i < 8; i++) digest_c[255 - 32*i -: 32] = h_q[i] + work_q[i];
    if (mode_q) digest_c[31:0] = '0;
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 8; i++) begin
        h_q[i]    <= '0;
        work_q[i] <= '0;
      end
      for (int j = 0; j < 16; j++) w_q[j] <= '0;
      rnd_q   <= '0;
      last_q  <= 1'b0;
      chain_q <= 1'b0;
      mode_q  <= 1'b0;
      md_o    <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          for (int j = 0; j < 16; j++) w_q[j] <= blk_i[511 - 32*j -: 32];
          rnd_q  <= '0;
          last_q <= last_i;
          if (restart) begin
            mode_q <= mode_sel;
            for (int i = 0; i < 8; i++) begin
              h_q[i]    <= iv_sel[i];
              work_q[i] <= iv_sel[i];
            end
          end else begin
            for (int i = 0; i < 8; i++) work_q[i] <= h_q[i];
          end
        end
        ROUND: begin
          w_q    <= w_d;
          work_q <= work_d;
          rnd_q  <= rnd_q + 6'd1;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + work_q[i];
          chain_q <= ~last_q;
          if (last_q) md_o <= digest_c;
        end
        DONE: if (md_ready_i) md_o <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream.sv
// Directed bench for sha256_stream: known-answer digests, latency, framing,
// backpressure and asynchronous reset, on a 1-round and a 4-round instance.
module tb_sha256_stream;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] M2_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M2_B2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] ABC_MD   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_MD = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] M2_MD    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] ABC224_MD = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic         blk_valid = 1'b0, first = 1'b0, last = 1'b0, mode224 = 1'b0, md_ready = 1'b0;
  logic [511:0] blk = '0;
  logic         blk_ready, md_valid, busy;
  logic [255:0] md;

  logic         b4_valid = 1'b0, b4_first = 1'b0, b4_last = 1'b0, b4_mode = 1'b0, b4_md_ready = 1'b0;
  logic [511:0] b4_blk = '0;
  logic         b4_ready, b4_md_valid, b4_busy;
  logic [255:0] b4_md;

  int errors = 0;
  int checks = 0;

  sha256_stream #(.ROUNDS_PER_CYCLE(1), .SUPPORT_224(1)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .blk_valid_i(blk_valid), .blk_ready_o(blk_ready), .blk_i(blk),
    .first_i(first), .last_i(last), .mode224_i(mode224),
    .md_o(md), .md_valid_o(md_valid), .md_ready_i(md_ready), .busy_o(busy)
  );

  sha256_stream #(.ROUNDS_PER_CYCLE(4), .SUPPORT_224(1)) dut4 (
    .clk_i(clk), .rstn_i(rstn),
    .blk_valid_i(b4_valid), .blk_ready_o(b4_ready), .blk_i(b4_blk),
    .first_i(b4_first), .last_i(b4_last), .mode224_i(b4_mode),
    .md_o(b4_md), .md_valid_o(b4_md_valid), .md_ready_i(b4_md_ready), .busy_o(b4_busy)
  );

  // Offer a block and hold it until accepted; returns just after the accepting edge.
  task automatic push(input logic [511:0] b, input logic f, input logic l,
                      input logic m, output logic ok);
    logic acc;
    acc = 1'b0;
    blk = b; first = f; last = l; mode224 = m; blk_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      acc = blk_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    blk_valid = 1'b0;
    ok = acc;
  endtask

  // Count edges from the accepting edge until md_valid rises (bounded).
  task automatic wait_md(output int n);
    n = 0;
    while (!md_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_md();
    md_ready = 1'b1;
    @(posedge clk); #1;
    md_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", blk_ready); end
    checks++; if (md_valid !== 1'b0) begin errors++; $display("FAIL reset_md_valid: got %b want 0", md_valid); end
    checks++; if (md !== 256'h0) begin errors++; $display("FAIL reset_md: got %h want 0", md); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (b4_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_r4: got %b want 1", b4_ready); end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_abc_256();
    logic ok; int n;
    push(ABC_BLK, 1'b1, 1'b1, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abc_accept: got %b want 1", ok); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abc_busy: got %b want 1", busy); end
    wait_md(n);
    checks++; if (n != 65) begin errors++; $display("FAIL abc_latency: got %0d want 65", n); end
    checks++; if (md !== ABC_MD) begin errors++; $display("FAIL abc_digest: got %h want %h", md, ABC_MD); end
    checks++; if (blk_ready !== 1'b0) begin errors++; $display("FAIL abc_ready_done: got %b want 0", blk_ready); end
    release_md();
    checks++; if (md_valid !== 1'b0 || md !== 256'h0) begin
      errors++; $display("FAIL abc_release: got valid=%b md=%h want 0/0", md_valid, md);
    end
    checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL abc_ready_idle: got %b want 1", blk_ready); end
  endtask

  task automatic test_abc_224();
    logic ok; int n;
    push(ABC_BLK, 1'b1, 1'b1, 1'b1, ok);
    wait_md(n);
    checks++; if (n != 65) begin errors++; $display("FAIL abc224_latency: got %0d want 65", n); end
    checks++; if (md !== ABC224_MD) begin errors++; $display("FAIL abc224_digest: got %h want %h", md, ABC224_MD); end
    release_md();
  endtask

  // Second block carries mode224=1 with first=0: the chained mode must stay SHA-256.
  task automatic test_two_block();
    logic ok; int n; int gap;
    push(M2_B1, 1'b1, 1'b0, 1'b0, ok);
    repeat (66) @(posedge clk);
    #1;
    checks++; if (md_valid !== 1'b0 || blk_ready !== 1'b1) begin
      errors++; $display("FAIL two_mid: got valid=%b ready=%b want 0/1", md_valid, blk_ready);
    end
    gap = int'($urandom_range(0, 9));
    repeat (gap) @(posedge clk);
    #1;
    push(M2_B2, 1'b0, 1'b1, 1'b1, ok);
    wait_md(n);
    checks++; if (n != 65) begin errors++; $display("FAIL two_latency: got %0d want 65", n); end
    checks++; if (md !== M2_MD) begin errors++; $display("FAIL two_digest: got %h want %h", md, M2_MD); end
    release_md();
  endtask

  task automatic test_restart();
    logic ok; int n;
    push(M2_B1, 1'b1, 1'b0, 1'b0, ok);
    repeat (66) @(posedge clk);
    #1;
    push(ABC_BLK, 1'b1, 1'b1, 1'b0, ok);
    wait_md(n);
    checks++; if (md !== ABC_MD) begin errors++; $display("FAIL restart_digest: got %h want %h", md, ABC_MD); end
    release_md();
  endtask

  task automatic test_back_to_back();
    logic ok; int n; int bad;
    push(ABC_BLK, 1'b1, 1'b1, 1'b0, ok);
    wait_md(n);
    blk = EMPTY_BLK; first = 1'b1; last = 1'b1; mode224 = 1'b0; blk_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (md !== ABC_MD || md_valid !== 1'b1 || blk_ready !== 1'b0) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL hold_cycle%0d: got md=%h valid=%b ready=%b want %h/1/0",
                              i, md, md_valid, blk_ready, ABC_MD);
      end
    end
    md_ready = 1'b1;
    @(posedge clk); #1;
    md_ready = 1'b0;
    checks++; if (busy !== 1'b0 || blk_ready !== 1'b1 || md_valid !== 1'b0) begin
      errors++; $display("FAIL handshake_idle: got busy=%b ready=%b valid=%b want 0/1/0", busy, blk_ready, md_valid);
    end
    @(posedge clk); #1;
    blk_valid = 1'b0;
    checks++; if (busy !== 1'b1 || blk_ready !== 1'b0) begin
      errors++; $display("FAIL next_accept: got busy=%b ready=%b want 1/0", busy, blk_ready);
    end
    wait_md(n);
    checks++; if (n != 65) begin errors++; $display("FAIL b2b_latency: got %0d want 65", n); end
    checks++; if (md !== EMPTY_MD) begin errors++; $display("FAIL b2b_digest: got %h want %h", md, EMPTY_MD); end
    release_md();
  endtask

  task automatic test_reset_mid_round();
    logic ok; int n;
    push(ABC_BLK, 1'b1, 1'b1, 1'b0, ok);
    repeat (30) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (blk_ready !== 1'b1 || busy !== 1'b0 || md_valid !== 1'b0 || md !== 256'h0) begin
      errors++; $display("FAIL midreset_outputs: got ready=%b busy=%b valid=%b md=%h want 1/0/0/0",
                         blk_ready, busy, md_valid, md);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    push(ABC_BLK, 1'b0, 1'b1, 1'b0, ok);
    wait_md(n);
    checks++; if (n != 65) begin errors++; $display("FAIL midreset_latency: got %0d want 65", n); end
    checks++; if (md !== ABC_MD) begin errors++; $display("FAIL midreset_digest: got %h want %h", md, ABC_MD); end
    release_md();
  endtask

  task automatic test_empty_r4();
    logic acc; int n;
    acc = 1'b0;
    b4_blk = EMPTY_BLK; b4_first = 1'b1; b4_last = 1'b1; b4_mode = 1'b0; b4_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      acc = b4_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    b4_valid = 1'b0;
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL r4_accept: got %b want 1", acc); end
    n = 0;
    while (!b4_md_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 17) begin errors++; $display("FAIL r4_latency: got %0d want 17", n); end
    checks++; if (b4_md !== EMPTY_MD) begin errors++; $display("FAIL r4_digest: got %h want %h", b4_md, EMPTY_MD); end
    b4_md_ready = 1'b1;
    @(posedge clk); #1;
    b4_md_ready = 1'b0;
    checks++; if (b4_md_valid !== 1'b0 || b4_md !== 256'h0) begin
      errors++; $display("FAIL r4_release: got valid=%b md=%h want 0/0", b4_md_valid, b4_md);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_abc_256();
    test_abc_224();
    test_two_block();
    test_restart();
    test_back_to_back();
    test_reset_mid_round();
    test_empty_r4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_stream.md
SHA256_STREAM -- requirements
Module: sha256_stream

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, legal 1/2/4: compression rounds evaluated per clock.
REQ-002 SHALL have parameter SUPPORT_224, default 1: 1 enables the SHA-224 mode; 0 ties the mode to SHA-256.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rstn_i  input  1  asynchronous, active-low reset.
REQ-005 blk_valid_i  input  1  padded 512-bit block present.
REQ-006 blk_ready_o  output  1  block can be accepted.
REQ-007 blk_i  input  512  block, word W0 in bits [511:480].
REQ-008 first_i  input  1  block starts a new message; qualified by the block handshake.
REQ-009 last_i  input  1  block ends the message; qualified by the block handshake.
REQ-010 mode224_i  input  1  SHA-224 select; sampled only when the accepted block has first_i=1.
REQ-011 md_o  output  256  digest.
REQ-012 md_valid_o  output  1  digest valid.
REQ-013 md_ready_i  input  1  digest consumed.
REQ-014 busy_o  output  1  state not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ROUND, UPDATE, DONE.
REQ-016 blk_ready_o SHALL be 1 only in IDLE.
REQ-017 Accept = blk_valid_i & blk_ready_o at a rising edge.
- Accept latches blk_i into the 16-word schedule window.
- Accept sets round counter = 0.
- Accept moves the FSM to ROUND.
REQ-018 On accept, the working variables a..h SHALL load from:
- IV (SHA-256 IV, or SHA-224 IV when the latched mode is 224), if first_i=1 or the chain is inactive;
- otherwise the current H0..H7.
REQ-019 ROUND SHALL advance ROUNDS_PER_CYCLE rounds per cycle, using standard K constants and an on-the-fly W schedule (no 64-word storage).
REQ-020 ROUND SHALL last exactly 64/ROUNDS_PER_CYCLE cycles, then go to UPDATE.
REQ-021 UPDATE (1 cycle) SHALL set each Hi = base_i + working_i mod 2^32, where base is the value loaded in REQ-018.
- If the block's last=1: set chain inactive, go to DONE.
- Else: set chain active, go to IDLE.
REQ-022 md_valid_o SHALL be 1 exactly in DONE; it rises 64/ROUNDS_PER_CYCLE+1 edges after the accepting edge (65 for R=1, 17 for R=4).
REQ-023 md_o in SHA-256 mode SHALL be H0..H7, H0 in MSBs.
REQ-024 md_o in SHA-224 mode SHALL be H0..H6 in [255:32], with [31:0]=0.
REQ-025 In DONE, md_o and md_valid_o SHALL hold stable until md_ready_i=1; that edge returns the FSM to IDLE.
REQ-026 A block accepted with first_i=0 while the chain is inactive SHALL be treated as first_i=1 using the mode from mode224_i.
REQ-027 first_i=1 while the chain is active SHALL discard the prior partial chain and restart from IV.
REQ-028 Inputs SHALL be ignored outside IDLE; no overlap of message blocks with digest hold.
REQ-029 md_o SHALL be 0 whenever md_valid_o=0.

Reset
REQ-030 rstn_i low SHALL asynchronously force all of the following, regardless of state, including mid-ROUND and during DONE:
- FSM to IDLE;
- H, working registers, schedule, counter and mode to 0;
- chain inactive.
REQ-031 Reset values: blk_ready_o=1, md_valid_o=0, md_o=0, busy_o=0.
REQ-032 The first block after reset SHALL hash from IV.

Verification
REQ-033 Single block "abc" (61626380_0..0_00000018), first=last=1, mode 256 -> md_o=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, md_valid_o at edge 65.
REQ-034 Empty string (80000000_0..0), ROUNDS_PER_CYCLE=4 -> md_o=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, md_valid_o at edge 17.
REQ-035 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" with first=1/last=0 then first=0/last=1, random blk_valid_i gaps between blocks -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-036 "abc" with mode224_i=1 -> md_o[255:32]=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, md_o[31:0]=0.
REQ-037 Backpressure: hold md_ready_i=0 for 20 cycles in DONE while driving blk_valid_i=1 -> md_o stable, blk_ready_o=0; no block accepted until the cycle after the md handshake.
REQ-038 Reset mid-ROUND (round 30) then "abc" -> outputs at reset values during reset; correct "abc" digest afterwards.
